// File: rtl/board_rst_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encoding,
// parameter defaults and small elaboration-time helpers.
package board_rst_pkg;

    typedef enum logic [2:0] {
        ST_POR        = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_MIG_RST    = 3'd2,
        ST_WAIT_CALIB = 3'd3,
        ST_SYS_DLY    = 3'd4,
        ST_RUN        = 3'd5,
        ST_NDM        = 3'd6,
        ST_FAIL       = 3'd7
    } state_e;

    localparam int POR_CYCLES_DEF     = 64;
    localparam int MIG_RST_CYCLES_DEF = 16;
    localparam int CALIB_TIMEOUT_DEF  = 4194304;
    localparam int MAX_RETRIES_DEF    = 3;
    localparam int SYS_DELAY_DEF      = 32;
    localparam int NDM_CYCLES_DEF     = 16;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must hold P-1 for the longest timed state; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/board_sync_ff.sv
// Multi-stage flop synchroniser for bringing asynchronous levels into the
// clk domain; every stage resets to 0.
module board_sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/board_rst_seq.sv
// Board bring-up reset sequencer: holds the MIG and SoC in reset through
// power-on, clock lock and DDR calibration, with retry, lock-loss and debug-reset handling.
module board_rst_seq
    import board_rst_pkg::*;
#(
    parameter int POR_CYCLES     = POR_CYCLES_DEF,
    parameter int MIG_RST_CYCLES = MIG_RST_CYCLES_DEF,
    parameter int CALIB_TIMEOUT  = CALIB_TIMEOUT_DEF,
    parameter int MAX_RETRIES    = MAX_RETRIES_DEF,
    parameter int SYS_DELAY      = SYS_DELAY_DEF,
    parameter int NDM_CYCLES     = NDM_CYCLES_DEF
) (
    input  logic       clk_p,
    input  logic       cpu_resetn,
    input  logic       clk_locked_i,
    input  logic       calib_done_i,
    input  logic       ndmreset_req_i,
    output logic       mig_rst_no,
    output logic       sys_rst_no,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o,
    output logic       fail_o
);

    localparam int MAX_TIMED = max_i(max_i(max_i(POR_CYCLES, MIG_RST_CYCLES),
                                           max_i(CALIB_TIMEOUT, SYS_DELAY)),
                                     NDM_CYCLES);
    localparam int CNT_W     = cnt_width(MAX_TIMED);

    localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIG_LAST   = CNT_W'(MIG_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SYS_LAST   = CNT_W'(SYS_DELAY - 1);
    localparam logic [CNT_W-1:0] NDM_LAST   = CNT_W'(NDM_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRIES);

    logic lock_s;
    logic calib_s;
    logic ndm_s;

    board_sync_ff #(.WIDTH(1), .STAGES(2)) u_sync_lock (
        .clk   (clk_p),
        .rst_n (cpu_resetn),
        .d     (clk_locked_i),
        .q     (lock_s)
    );

    board_sync_ff #(.WIDTH(1), .STAGES(2)) u_sync_calib (
        .clk   (clk_p),
        .rst_n (cpu_resetn),
        .d     (calib_done_i),
        .q     (calib_s)
    );

    board_sync_ff #(.WIDTH(1), .STAGES(2)) u_sync_ndm (
        .clk   (clk_p),
        .rst_n (cpu_resetn),
        .d     (ndmreset_req_i),
        .q     (ndm_s)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [1:0]       retry_d, retry_q;
    logic             mig_rst_n_d, mig_rst_n_q;
    logic             sys_rst_n_d, sys_rst_n_q;
    logic             fail_d, fail_q;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path through the logic can leave one unassigned and infer a latch.
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) state_d = ST_MIG_RST;
            end
            ST_MIG_RST: begin
                if (!lock_s)                state_d = ST_WAIT_LOCK;
                else if (cnt_q == MIG_LAST) state_d = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (calib_s) begin
                    state_d = ST_SYS_DLY;
                end else if (cnt_q == CALIB_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_MIG_RST;
                        retry_d = (retry_q == 2'b11) ? retry_q : retry_q + 2'd1;
                    end
                end
            end
            // Calibration loss after bring-up re-resets the MIG without
            // consuming a retry; lock loss always wins over it.
            ST_SYS_DLY: begin
                if (!lock_s)                state_d = ST_WAIT_LOCK;
                else if (!calib_s)          state_d = ST_MIG_RST;
                else if (cnt_q == SYS_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s)       state_d = ST_WAIT_LOCK;
                else if (!calib_s) state_d = ST_MIG_RST;
                else if (ndm_s)    state_d = ST_NDM;
            end
            ST_NDM: begin
                if (!lock_s)                          state_d = ST_WAIT_LOCK;
                else if (!calib_s)                    state_d = ST_MIG_RST;
                else if (cnt_q >= NDM_LAST && !ndm_s) state_d = ST_RUN;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_POR;
            end
        endcase

        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

        // Saturating so a long debug-reset hold cannot wrap below NDM_LAST.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == '1)    cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so their flops line up with state_q.
        mig_rst_n_d = !(state_d inside {ST_POR, ST_WAIT_LOCK, ST_MIG_RST, ST_FAIL});
        sys_rst_n_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_p or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q     <= ST_POR;
            cnt_q       <= '0;
            retry_q     <= '0;
            mig_rst_n_q <= 1'b0;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            mig_rst_n_q <= mig_rst_n_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    assign mig_rst_no  = mig_rst_n_q;
    assign sys_rst_no  = sys_rst_n_q;
    assign fail_o      = fail_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_board_rst_seq.sv
// Self-checking bench for board_rst_seq: a cycle-stamped vector table drives the
// inputs and queues expected outputs, with hand sequences for reset corner cases.
module tb_board_rst_seq;

    localparam logic [2:0] S_POR  = 3'd0;
    localparam logic [2:0] S_WL   = 3'd1;
    localparam logic [2:0] S_MIG  = 3'd2;
    localparam logic [2:0] S_WC   = 3'd3;
    localparam logic [2:0] S_SYS  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_NDM  = 3'd6;
    localparam logic [2:0] S_FAIL = 3'd7;

    logic       clk_p          = 1'b0;
    logic       cpu_resetn     = 1'b1;
    logic       clk_locked_i   = 1'b0;
    logic       calib_done_i   = 1'b0;
    logic       ndmreset_req_i = 1'b0;
    logic       mig_rst_no;
    logic       sys_rst_no;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;
    logic       fail_o;

    typedef struct {
        int         at;
        logic       lock;
        logic       calib;
        logic       ndm;
        logic [2:0] st;
        logic       mig;
        logic       sys;
        logic       fail;
        logic [1:0] retry;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    board_rst_seq #(
        .POR_CYCLES     (8),
        .MIG_RST_CYCLES (4),
        .CALIB_TIMEOUT  (32),
        .MAX_RETRIES    (2),
        .SYS_DELAY      (4),
        .NDM_CYCLES     (4)
    ) dut (
        .clk_p          (clk_p),
        .cpu_resetn     (cpu_resetn),
        .clk_locked_i   (clk_locked_i),
        .calib_done_i   (calib_done_i),
        .ndmreset_req_i (ndmreset_req_i),
        .mig_rst_no     (mig_rst_no),
        .sys_rst_no     (sys_rst_no),
        .state_o        (state_o),
        .retry_cnt_o    (retry_cnt_o),
        .fail_o         (fail_o)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int at, input logic lock, input logic calib,
                                input logic ndm, input logic [2:0] st, input logic mig,
                                input logic sys, input logic fail, input logic [1:0] retry);
        vec_t v;
        v.at = at; v.lock = lock; v.calib = calib; v.ndm = ndm;
        v.st = st; v.mig = mig; v.sys = sys; v.fail = fail; v.retry = retry;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drain();
        vec_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL c%0d missed: reached at cycle %0d", e.at, cyc);
            end else begin
                check($sformatf("c%0d state_o", e.at), state_o, e.st);
                check($sformatf("c%0d mig_rst_no", e.at), mig_rst_no, e.mig);
                check($sformatf("c%0d sys_rst_no", e.at), sys_rst_no, e.sys);
                check($sformatf("c%0d fail_o", e.at), fail_o, e.fail);
                check($sformatf("c%0d retry_cnt_o", e.at), retry_cnt_o, e.retry);
            end
        end
    endtask

    // Outputs are sampled on the falling edge, half a period after the state update.
    task automatic tick();
        @(posedge clk_p);
        cyc++;
        @(negedge clk_p);
        drain();
    endtask

    task automatic run_until(input int t);
        drain();
        while (cyc < t) tick();
    endtask

    task automatic apply(input vec_t v);
        sb.push_back(v);
        run_until(v.at);
        clk_locked_i   = v.lock;
        calib_done_i   = v.calib;
        ndmreset_req_i = v.ndm;
    endtask

    // Asserts reset from a falling edge, checks the asynchronous effect at once,
    // then releases on a later falling edge; cycle 0 is the release point.
    task automatic do_reset();
        cpu_resetn = 1'b0;
        #1;
        check("rst state_o", state_o, S_POR);
        check("rst mig_rst_no", mig_rst_no, 1'b0);
        check("rst sys_rst_no", sys_rst_no, 1'b0);
        check("rst fail_o", fail_o, 1'b0);
        check("rst retry_cnt_o", retry_cnt_o, 2'd0);
        repeat (3) @(negedge clk_p);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover expectations: %0d entries pending", sb.size());
            sb.delete();
        end
        cpu_resetn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        //                at  lock calib ndm state   mig sys fail retry
        // Nominal bring-up: mig_rst_no rises at 13, calib driven after 23, RUN at 30.
        vecs.push_back(mk(  0, 1, 0, 0, S_POR,  0, 0, 0, 0));
        vecs.push_back(mk(  7, 1, 0, 0, S_POR,  0, 0, 0, 0));
        vecs.push_back(mk(  8, 1, 0, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk(  9, 1, 0, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk( 12, 1, 0, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk( 13, 1, 0, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk( 23, 1, 1, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk( 25, 1, 1, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk( 26, 1, 1, 0, S_SYS,  1, 0, 0, 0));
        vecs.push_back(mk( 29, 1, 1, 0, S_SYS,  1, 0, 0, 0));
        vecs.push_back(mk( 30, 1, 1, 0, S_RUN,  1, 1, 0, 0));
        // Short debug reset (2 cycles): sys_rst_no low for cycles 38..41.
        vecs.push_back(mk( 35, 1, 1, 1, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 37, 1, 1, 0, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 38, 1, 1, 0, S_NDM,  1, 0, 0, 0));
        vecs.push_back(mk( 41, 1, 1, 0, S_NDM,  1, 0, 0, 0));
        vecs.push_back(mk( 42, 1, 1, 0, S_RUN,  1, 1, 0, 0));
        // Long debug reset (10 cycles): released after 60, RUN again at 63.
        vecs.push_back(mk( 50, 1, 1, 1, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 52, 1, 1, 1, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 53, 1, 1, 1, S_NDM,  1, 0, 0, 0));
        vecs.push_back(mk( 60, 1, 1, 0, S_NDM,  1, 0, 0, 0));
        vecs.push_back(mk( 62, 1, 1, 0, S_NDM,  1, 0, 0, 0));
        vecs.push_back(mk( 63, 1, 1, 0, S_RUN,  1, 1, 0, 0));
        // Lock loss in RUN: both resets low 3 cycles later; relock redoes MIG bring-up.
        vecs.push_back(mk( 70, 0, 1, 0, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 72, 0, 1, 0, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk( 73, 0, 1, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk( 80, 1, 1, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk( 82, 1, 1, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk( 83, 1, 1, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk( 86, 1, 1, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk( 87, 1, 1, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk( 88, 1, 1, 0, S_SYS,  1, 0, 0, 0));
        vecs.push_back(mk( 91, 1, 1, 0, S_SYS,  1, 0, 0, 0));
        vecs.push_back(mk( 92, 1, 1, 0, S_RUN,  1, 1, 0, 0));
        // Lock and calib drop together: lock loss wins.
        vecs.push_back(mk(100, 0, 0, 0, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk(102, 0, 0, 0, S_RUN,  1, 1, 0, 0));
        vecs.push_back(mk(103, 0, 0, 0, S_WL,   0, 0, 0, 0));
        // Relock with calib stuck low: three 36-cycle attempts, then FAIL at 221.
        vecs.push_back(mk(110, 1, 0, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk(112, 1, 0, 0, S_WL,   0, 0, 0, 0));
        vecs.push_back(mk(113, 1, 0, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk(116, 1, 0, 0, S_MIG,  0, 0, 0, 0));
        vecs.push_back(mk(117, 1, 0, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk(148, 1, 0, 0, S_WC,   1, 0, 0, 0));
        vecs.push_back(mk(149, 1, 0, 0, S_MIG,  0, 0, 0, 1));
        vecs.push_back(mk(152, 1, 0, 0, S_MIG,  0, 0, 0, 1));
        vecs.push_back(mk(153, 1, 0, 0, S_WC,   1, 0, 0, 1));
        vecs.push_back(mk(184, 1, 0, 0, S_WC,   1, 0, 0, 1));
        vecs.push_back(mk(185, 1, 0, 0, S_MIG,  0, 0, 0, 2));
        vecs.push_back(mk(188, 1, 0, 0, S_MIG,  0, 0, 0, 2));
        vecs.push_back(mk(189, 1, 0, 0, S_WC,   1, 0, 0, 2));
        vecs.push_back(mk(220, 1, 0, 0, S_WC,   1, 0, 0, 2));
        vecs.push_back(mk(221, 1, 0, 0, S_FAIL, 0, 0, 1, 2));
        vecs.push_back(mk(230, 0, 1, 0, S_FAIL, 0, 0, 1, 2));
        vecs.push_back(mk(260, 0, 1, 0, S_FAIL, 0, 0, 1, 2));

        clk_locked_i   = 1'b1;
        calib_done_i   = 1'b0;
        ndmreset_req_i = 1'b0;
        @(negedge clk_p);
        do_reset();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset out of FAIL, then a cpu_resetn pulse during the second calibration attempt.
        clk_locked_i   = 1'b1;
        calib_done_i   = 1'b0;
        ndmreset_req_i = 1'b0;
        do_reset();
        sb.push_back(mk(45, 1, 0, 0, S_MIG, 0, 0, 0, 1));
        sb.push_back(mk(49, 1, 0, 0, S_WC,  1, 0, 0, 1));
        sb.push_back(mk(55, 1, 0, 0, S_WC,  1, 0, 0, 1));
        run_until(55);
        do_reset();

        // After the mid-operation reset the full nominal bring-up must replay.
        for (int i = 0; i < vecs.size() && vecs[i].at <= 30; i++) apply(vecs[i]);
        run_until(cyc + 2);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover expectations: %0d entries pending", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_rst_seq.md
BOARD_RST_SEQ -- requirements
Module: board_rst_seq

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 64, giving the power-on hold length in clk_p cycles.
REQ-002 SHALL have parameter MIG_RST_CYCLES, default 16, giving the length of the MIG reset pulse.
REQ-003 SHALL have parameter CALIB_TIMEOUT, default 2^22, giving the maximum wait for calibration per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, giving the number of MIG re-reset attempts before failure; MAX_RETRIES <= 3.
REQ-005 SHALL have parameter SYS_DELAY, default 32, giving the delay from calibration to system reset release.
REQ-006 SHALL have parameter NDM_CYCLES, default 16, giving the minimum debug-reset hold length.
REQ-007 SHALL have port clk_p, input, width 1: board clock.
REQ-008 SHALL have port cpu_resetn, input, width 1: asynchronous active-low reset.
REQ-009 SHALL have port clk_locked_i, input, width 1: clock-wizard lock, asynchronous.
REQ-010 SHALL have port calib_done_i, input, width 1: MIG init_calib_complete, asynchronous (ui_clk domain).
REQ-011 SHALL have port ndmreset_req_i, input, width 1: debug-module reset request, asynchronous level.
REQ-012 SHALL have port mig_rst_no, output, width 1: active-low MIG sys_rst.
REQ-013 SHALL have port sys_rst_no, output, width 1: active-low SoC/peripheral reset.
REQ-014 SHALL have port state_o, output, width 3: current FSM state encoding.
REQ-015 SHALL have port retry_cnt_o, output, width 2: number of calibration retries in the current bring-up.
REQ-016 SHALL have port fail_o, output, width 1: bring-up failed.

Function
REQ-017 SHALL pass clk_locked_i, calib_done_i and ndmreset_req_i through 2-flop synchronisers (reset value 0) before use; the synchronised versions are lock_s, calib_s and ndm_s.
REQ-018 SHALL implement the FSM states POR=0, WAIT_LOCK=1, MIG_RST=2, WAIT_CALIB=3, SYS_DLY=4, RUN=5, NDM=6, FAIL=7.
REQ-019 SHALL clear the cycle counter on every state change and increment it each cycle otherwise; a timed state P exits when the counter equals P-1, so it lasts exactly P cycles.
REQ-020 SHALL move POR -> WAIT_LOCK after POR_CYCLES cycles.
REQ-021 SHALL move WAIT_LOCK -> MIG_RST in the first cycle lock_s=1.
REQ-022 SHALL move MIG_RST -> WAIT_CALIB after MIG_RST_CYCLES cycles.
REQ-023 SHALL move WAIT_CALIB -> SYS_DLY when calib_s=1.
REQ-024 SHALL, on WAIT_CALIB timeout, go to FAIL if retry_cnt==MAX_RETRIES; otherwise it SHALL increment retry_cnt and go to MIG_RST.
REQ-025 SHALL move SYS_DLY -> RUN after SYS_DELAY cycles and clear retry_cnt on RUN entry.
REQ-026 SHALL move RUN -> NDM when ndm_s=1.
REQ-027 SHALL move NDM -> RUN only when the counter is >= NDM_CYCLES-1 and ndm_s=0; the counter SHALL saturate rather than wrap.
REQ-028 SHALL, from MIG_RST, WAIT_CALIB, SYS_DLY, RUN or NDM, go to WAIT_LOCK on lock_s=0; this has the highest priority.
REQ-029 SHALL, from SYS_DLY, RUN or NDM, go to MIG_RST on calib_s=0 without incrementing retry_cnt; this has second priority, above timeouts and ndm_s.
REQ-030 SHALL treat FAIL as terminal until cpu_resetn is asserted.
REQ-031 SHALL drive all outputs from flops updated on the same edge as the state register, with no combinational input-to-output path.
REQ-032 SHALL drive mig_rst_no=0 in POR, WAIT_LOCK, MIG_RST and FAIL, and 1 otherwise.
REQ-033 SHALL drive sys_rst_no=1 only in RUN.
REQ-034 SHALL drive fail_o=1 only in FAIL.
REQ-035 SHALL drive state_o equal to the state register.
REQ-036 SHALL size the counter to $clog2 of the largest timed parameter, and size retry_cnt at 2 bits with saturation.

Reset
REQ-037 SHALL, while cpu_resetn=0, asynchronously force state=POR, counter=0, retry_cnt=0, synchronisers=0, mig_rst_no=0, sys_rst_no=0, fail_o=0, state_o=0 and retry_cnt_o=0.
REQ-038 SHALL release reset synchronously; assertion of reset mid-operation from any state SHALL restart the full bring-up sequence.

Structure
REQ-039 SHALL place the state enum, its 3-bit encoding and the parameter defaults in the shared package board_rst_pkg.
REQ-040 SHALL instantiate the synchroniser as a sub-module board_sync_ff (parameterised width and stage count), one instance per asynchronous input.

Verification (POR=8, MIG_RST=4, CALIB_TIMEOUT=32, MAX_RETRIES=2, SYS_DELAY=4, NDM=4)
REQ-041 SHALL verify nominal bring-up: with lock held at 1 and calib rising 10 cycles after mig_rst_no rises, mig_rst_no rises 13 cycles after the first edge and sys_rst_no rises 7 cycles after calib_done_i rises (2 sync + 1 + 4).
REQ-042 SHALL verify calibration failure: with calib held at 0, retry_cnt_o steps 1 then 2, each attempt lasts 4+32 cycles, then state_o=7 and fail_o=1 with both resets low indefinitely.
REQ-043 SHALL verify lock loss: clk_locked_i dropping in RUN drives mig_rst_no and sys_rst_no low 3 cycles later with state_o=1; relock redoes MIG_RST and WAIT_CALIB.
REQ-044 SHALL verify debug reset: ndmreset_req_i high for 2 cycles gives sys_rst_no low for exactly 4 cycles; held for 10 cycles it stays low until 3 cycles after release; mig_rst_no stays 1 throughout.
REQ-045 SHALL verify mid-operation reset: cpu_resetn pulsed low during WAIT_CALIB with retry_cnt_o=1 immediately yields state_o=0, retry_cnt_o=0 and both resets low, followed by a full nominal sequence.
REQ-046 SHALL verify priority: lock and calib dropping in the same cycle while in RUN results in WAIT_LOCK, not MIG_RST.
